uart_rx_data_sampler: RTL and testbench
=======================================

// Module: uart_rx_data_sampler
// PURPOSE
//  UART RX front-end stage: synchronises rx_in, runs the oversampling edge/bit counters and majority-votes
//  three mid-bit samples into one sampled_bit per bit period. Sits between the RX pin and the RX FSM /
//  deserializer / parity / stop checkers. Those blocks consume sampled_bit, sample_valid, edge_cnt and bit_cnt.
// PARAMETERS
//  Prescale_width  6   width of prescale and edge_cnt; legal prescale values 8, 16, 32
//  Bitcnt_width    4   width of bit_cnt; covers start + 8 data + parity + stop = 11 bits
//  Sync_stages     2   flip-flop stages on rx_in; minimum 2
// PORTS
//  clk           in   1                 oversampling clock (prescale x baud)
//  reset_n       in   1                 asynchronous active-low reset
//  rx_in         in   1                 raw serial line; idles high
//  prescale      in   Prescale_width    oversampling ratio; stable while cnt_en=1
//  cnt_en        in   1                 from RX FSM; 1 = frame in progress, run counters
//  dat_samp_en   in   1                 from RX FSM; 1 = take mid-bit samples
//  edge_cnt      out  Prescale_width    position inside the current bit, 0..prescale-1
//  bit_cnt       out  Bitcnt_width      index of the current bit within the frame
//  bit_done      out  1                 1-cycle pulse when edge_cnt==prescale-1 and cnt_en=1
//  sampled_bit   out  1                 majority-voted value of the last completed sample
//  sample_valid  out  1                 1-cycle strobe: sampled_bit was updated this cycle
//  rx_sync       out  1                 synchronised rx_in; the RX FSM uses it for start detect
// BEHAVIOUR
//  Reset (async, reset_n=0)
//   - edge_cnt=0, bit_cnt=0, bit_done=0, sample_valid=0.
//   - sampled_bit=1; sync chain=all 1s, so rx_sync=1.
//   - Reset mid-frame aborts everything and discards partial samples.
//  Synchroniser: rx_sync lags rx_in by Sync_stages cycles. The RX FSM accounts for this latency.
//  Counters, cnt_en=1
//   - edge_cnt increments each clk.
//   - When edge_cnt >= prescale-1: edge_cnt <= 0, bit_cnt <= bit_cnt+1, and bit_done is asserted
//     combinationally in that cycle.
//   - The >= comparison keeps the counter bounded if prescale changes illegally mid-frame.
//   - bit_cnt saturates at all-ones; it never wraps.
//  Counters, cnt_en=0: edge_cnt and bit_cnt clear to 0 on the next clk; bit_done=0.
//  Sampling points: mid = prescale>>1. Capture points are edge_cnt == mid-1, mid, mid+1
//   (prescale=8 -> 3,4,5; prescale=16 -> 7,8,9).
//   - A sample is captured only when cnt_en=1, dat_samp_en=1 and edge_cnt matches a capture point.
//   - At the clk edge where edge_cnt==mid+1:
//       sampled_bit <= majority(s0, s1, rx_sync) = (a&b)|(a&c)|(b&c);
//       sample_valid <= 1 for exactly one cycle.
//     Both are visible while edge_cnt==mid+2.
//   - If dat_samp_en or cnt_en is 0 at any of the three points, that bit produces no sample_valid.
//     sampled_bit holds its old value and the sample registers are cleared at the next edge_cnt==0.
//  Between strobes, sampled_bit holds its value.
//  Sample latency: last capture edge -> sample_valid high = 1 clk.
//  Unsupported: prescale < 4, or changing prescale while cnt_en=1. Behaviour is bounded but
//   sampled_bit is not guaranteed correct.
// STRUCTURE
//  Package uart_rx_pkg:
//   - PRESCALE_W = 6, BITCNT_W = 4
//   - function mid_point(prescale)
//   - localparams for legal prescale values 8/16/32
//  Sub-module uart_edge_bit_counter: owns edge_cnt, bit_cnt, bit_done.
//  This module instantiates it and adds the synchroniser, the 2-entry sample register and the majority vote.
// TESTING
//  1. Reset, then hold rx_in=1 with cnt_en=0 -> all outputs at reset values; edge_cnt stays 0.
//  2. prescale=8, cnt_en=1 for 24 clks -> edge_cnt sequence 0..7 three times; bit_done pulses at clk 8,16,24;
//     bit_cnt 0->1->2->3.
//  3. prescale=8, dat_samp_en=1, rx_sync=0 for a whole bit -> sample_valid pulses when edge_cnt==6;
//     sampled_bit=0.
//  4. prescale=16, glitch rx_sync=0 only at edge_cnt==8 (samples 1,0,1) -> sampled_bit=1.
//     Glitch at 7 and 8 (samples 0,0,1) -> sampled_bit=0.
//  5. prescale=8, drop dat_samp_en at edge_cnt==4 -> no sample_valid in that bit; sampled_bit unchanged;
//     next full bit samples normally.
//  6. Assert reset_n=0 at edge_cnt==5, bit_cnt==3 -> all outputs return immediately to reset values.
//     Release with cnt_en=1 -> counting restarts from edge_cnt=0, bit_cnt=0.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// ----------------------------------------------------------------------------
// uart_rx_pkg
//   Shared widths, legal prescale values and small helpers for the UART RX
//   front end (data sampler and edge/bit counter).
// ----------------------------------------------------------------------------
package uart_rx_pkg;

    localparam int PRESCALE_W = 6;
    localparam int BITCNT_W   = 4;

    localparam logic [PRESCALE_W-1:0] PRESCALE_8  = PRESCALE_W'(8);
    localparam logic [PRESCALE_W-1:0] PRESCALE_16 = PRESCALE_W'(16);
    localparam logic [PRESCALE_W-1:0] PRESCALE_32 = PRESCALE_W'(32);

    // Which of the three mid-bit capture points the edge counter is sitting on.
    typedef enum logic [1:0] {
        CAP_NONE,
        CAP_FIRST,   // mid-1 : first sample
        CAP_SECOND,  // mid   : second sample
        CAP_VOTE     // mid+1 : third sample, vote and publish
    } capture_point_e;

    function automatic logic [PRESCALE_W-1:0] mid_point(input logic [PRESCALE_W-1:0] prescale);
        return prescale >> 1;
    endfunction

    function automatic logic prescale_is_legal(input logic [PRESCALE_W-1:0] prescale);
        return (prescale == PRESCALE_8) || (prescale == PRESCALE_16) || (prescale == PRESCALE_32);
    endfunction

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_data_sampler_counter.sv
// ----------------------------------------------------------------------------
// uart_edge_bit_counter
//   Oversampling position counter (edge_cnt) and frame bit index (bit_cnt).
//   Counts only while cnt_en=1; clears on the first clock with cnt_en=0.
// Ports
//   clk, reset_n  clock, asynchronous active-low reset
//   prescale      oversampling ratio (edge_cnt wraps after prescale-1)
//   cnt_en        run the counters
//   edge_cnt      position inside the current bit, 0..prescale-1
//   bit_cnt       bit index within the frame, saturates at all-ones
//   bit_done      combinational pulse in the last edge of each bit
// ----------------------------------------------------------------------------
module uart_edge_bit_counter
    import uart_rx_pkg::*;
#(
    parameter int Prescale_width = PRESCALE_W,
    parameter int Bitcnt_width   = BITCNT_W
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [Prescale_width-1:0] prescale,
    input  logic                      cnt_en,
    output logic [Prescale_width-1:0] edge_cnt,
    output logic [Bitcnt_width-1:0]   bit_cnt,
    output logic                      bit_done
);

    logic last_edge;

    // >= rather than == so the counter still wraps if prescale shrinks mid-frame.
    assign last_edge = edge_cnt >= (prescale - Prescale_width'(1));
    assign bit_done  = cnt_en && last_edge;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
        end else if (!cnt_en) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
        end else if (last_edge) begin
            edge_cnt <= '0;
            if (bit_cnt != '1) begin
                bit_cnt <= bit_cnt + Bitcnt_width'(1);
            end
        end else begin
            edge_cnt <= edge_cnt + Prescale_width'(1);
        end
    end

endmodule

// File: rtl/uart_rx_data_sampler.sv
// ----------------------------------------------------------------------------
// uart_rx_data_sampler
//   UART RX front end: synchronises rx_in, runs the edge/bit counters and
//   majority-votes three mid-bit samples into one sampled_bit per bit.
// Ports
//   clk, reset_n  oversampling clock, asynchronous active-low reset
//   rx_in         raw serial line (idles high)
//   prescale      oversampling ratio, stable while cnt_en=1
//   cnt_en        frame in progress, run counters
//   dat_samp_en   take mid-bit samples
//   edge_cnt      position inside current bit
//   bit_cnt       bit index within frame
//   bit_done      last-edge-of-bit pulse
//   sampled_bit   majority-voted value of the last completed sample
//   sample_valid  one-cycle strobe: sampled_bit updated this cycle
//   rx_sync       synchronised rx_in (Sync_stages cycles of latency)
// ----------------------------------------------------------------------------
module uart_rx_data_sampler
    import uart_rx_pkg::*;
#(
    parameter int Prescale_width = PRESCALE_W,
    parameter int Bitcnt_width   = BITCNT_W,
    parameter int Sync_stages    = 2
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      rx_in,
    input  logic [Prescale_width-1:0] prescale,
    input  logic                      cnt_en,
    input  logic                      dat_samp_en,
    output logic [Prescale_width-1:0] edge_cnt,
    output logic [Bitcnt_width-1:0]   bit_cnt,
    output logic                      bit_done,
    output logic                      sampled_bit,
    output logic                      sample_valid,
    output logic                      rx_sync
);

    logic [Sync_stages-1:0]    sync_q;
    logic [Prescale_width-1:0] mid;
    logic [Prescale_width-1:0] cap_first;
    logic [Prescale_width-1:0] cap_vote;
    capture_point_e            cap_point;
    logic                      take;
    logic                      s0, s1;
    logic                      have_s0, have_s1;

    uart_edge_bit_counter #(
        .Prescale_width (Prescale_width),
        .Bitcnt_width   (Bitcnt_width)
    ) u_counter (
        .clk      (clk),
        .reset_n  (reset_n),
        .prescale (prescale),
        .cnt_en   (cnt_en),
        .edge_cnt (edge_cnt),
        .bit_cnt  (bit_cnt),
        .bit_done (bit_done)
    );

    // Synchroniser presets to the idle level so the RX FSM never sees a false
    // start bit coming out of reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[Sync_stages-2:0], rx_in};
        end
    end

    assign rx_sync = sync_q[Sync_stages-1];

    assign mid       = Prescale_width'(mid_point(PRESCALE_W'(prescale)));
    assign cap_first = mid - Prescale_width'(1);
    assign cap_vote  = mid + Prescale_width'(1);
    assign take      = cnt_en && dat_samp_en;

    // NOTE: every path assigns cap_point up front, so no latch is inferred.
    always_comb begin
        cap_point = CAP_NONE;
        if (edge_cnt == cap_first) begin
            cap_point = CAP_FIRST;
        end else if (edge_cnt == mid) begin
            cap_point = CAP_SECOND;
        end else if (edge_cnt == cap_vote) begin
            cap_point = CAP_VOTE;
        end
    end

    // have_s0/have_s1 record that each earlier capture really happened, so a
    // bit with dat_samp_en dropped at any capture point never publishes.
    // NOTE: the two sample registers are plain flops, not a memory array, so
    // they are reset along with the rest of the state to discard partial bits.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s0           <= 1'b1;
            s1           <= 1'b1;
            have_s0      <= 1'b0;
            have_s1      <= 1'b0;
            sampled_bit  <= 1'b1;
            sample_valid <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            if (edge_cnt == '0) begin
                s0      <= 1'b1;
                s1      <= 1'b1;
                have_s0 <= 1'b0;
                have_s1 <= 1'b0;
            end
            if (take) begin
                case (cap_point)
                    CAP_FIRST: begin
                        s0      <= rx_sync;
                        have_s0 <= 1'b1;
                    end
                    CAP_SECOND: begin
                        s1      <= rx_sync;
                        have_s1 <= 1'b1;
                    end
                    CAP_VOTE: begin
                        if (have_s0 && have_s1) begin
                            sampled_bit  <= majority3(s0, s1, rx_sync);
                            sample_valid <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_data_sampler.sv
module tb_uart_rx_data_sampler;
    import uart_rx_pkg::*;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       rx_in;
    logic [5:0] prescale;
    logic       cnt_en;
    logic       dat_samp_en;
    logic [5:0] edge_cnt;
    logic [3:0] bit_cnt;
    logic       bit_done;
    logic       sampled_bit;
    logic       sample_valid;
    logic       rx_sync;

    int checks = 0;
    int passes = 0;

    // Per-cycle stimulus plan (desired rx_sync and dat_samp_en at cycle i of a frame)
    // and per-cycle observations taken on the falling edge.
    logic       plan     [0:299];
    logic       en_plan  [0:299];
    logic       obs_valid[0:299];
    logic       obs_bit  [0:299];
    logic       obs_sync [0:299];
    logic       obs_done [0:299];
    logic [5:0] obs_edge [0:299];
    logic [3:0] obs_bcnt [0:299];

    uart_rx_data_sampler dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .rx_in        (rx_in),
        .prescale     (prescale),
        .cnt_en       (cnt_en),
        .dat_samp_en  (dat_samp_en),
        .edge_cnt     (edge_cnt),
        .bit_cnt      (bit_cnt),
        .bit_done     (bit_done),
        .sampled_bit  (sampled_bit),
        .sample_valid (sample_valid),
        .rx_sync      (rx_sync)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time exceeded, got timeout expected finish");
        $fatal(1);
    end

    task automatic clear_plan();
        for (int i = 0; i < 300; i++) begin
            plan[i]    = 1'b1;
            en_plan[i] = 1'b0;
        end
    endtask

    // Runs an n-cycle frame with cnt_en=1. rx_in is driven two cycles ahead so
    // that rx_sync in frame cycle i equals plan[i]. Called and returns on a negedge.
    task automatic run_frame(input int n);
        rx_in = plan[0];
        @(negedge clk);
        rx_in = plan[1];
        @(negedge clk);
        for (int i = 0; i < n; i++) begin
            obs_valid[i] = sample_valid;
            obs_bit[i]   = sampled_bit;
            obs_sync[i]  = rx_sync;
            obs_done[i]  = bit_done;
            obs_edge[i]  = edge_cnt;
            obs_bcnt[i]  = bit_cnt;
            cnt_en       = 1'b1;
            dat_samp_en  = en_plan[i];
            rx_in        = plan[i+2];
            @(negedge clk);
        end
        cnt_en      = 1'b0;
        dat_samp_en = 1'b0;
        rx_in       = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; rx_in = 1'b1; cnt_en = 1'b0; dat_samp_en = 1'b0; prescale = PRESCALE_8;
        repeat (3) @(negedge clk);
        checks++; if (edge_cnt !== 6'd0) $display("FAIL reset_edge_cnt: got %0d expected 0", edge_cnt); else passes++;
        checks++; if (bit_cnt !== 4'd0) $display("FAIL reset_bit_cnt: got %0d expected 0", bit_cnt); else passes++;
        checks++; if (bit_done !== 1'b0) $display("FAIL reset_bit_done: got %b expected 0", bit_done); else passes++;
        checks++; if (sampled_bit !== 1'b1) $display("FAIL reset_sampled_bit: got %b expected 1", sampled_bit); else passes++;
        checks++; if (sample_valid !== 1'b0) $display("FAIL reset_sample_valid: got %b expected 0", sample_valid); else passes++;
        checks++; if (rx_sync !== 1'b1) $display("FAIL reset_rx_sync: got %b expected 1", rx_sync); else passes++;
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++; if (edge_cnt !== 6'd0) $display("FAIL idle_edge_cnt[%0d]: got %0d expected 0", i, edge_cnt); else passes++;
            checks++; if (sample_valid !== 1'b0 || bit_done !== 1'b0) $display("FAIL idle_strobes[%0d]: got valid=%b done=%b expected 0/0", i, sample_valid, bit_done); else passes++;
            checks++; if (rx_sync !== 1'b1 || sampled_bit !== 1'b1) $display("FAIL idle_levels[%0d]: got sync=%b bit=%b expected 1/1", i, rx_sync, sampled_bit); else passes++;
        end
    endtask

    task automatic test_counting();
        clear_plan();
        prescale = PRESCALE_8;
        run_frame(25);
        for (int i = 1; i < 25; i++) begin
            checks++; if (obs_edge[i] !== 6'(i % 8)) $display("FAIL count_edge[%0d]: got %0d expected %0d", i, obs_edge[i], i % 8); else passes++;
            checks++; if (obs_bcnt[i] !== 4'(i / 8)) $display("FAIL count_bit[%0d]: got %0d expected %0d", i, obs_bcnt[i], i / 8); else passes++;
            checks++; if (obs_done[i] !== ((i % 8) == 7)) $display("FAIL count_done[%0d]: got %b expected %b", i, obs_done[i], (i % 8) == 7); else passes++;
        end
        @(negedge clk);
        checks++; if (edge_cnt !== 6'd0 || bit_cnt !== 4'd0) $display("FAIL count_clear: got edge=%0d bit=%0d expected 0/0", edge_cnt, bit_cnt); else passes++;
    endtask

    task automatic test_majority_p8();
        clear_plan();
        prescale = PRESCALE_8;
        for (int i = 0; i < 8; i++) begin
            plan[i]    = 1'b0;
            en_plan[i] = 1'b1;
        end
        run_frame(8);
        checks++; if (obs_sync[0] !== 1'b0) $display("FAIL p8_sync_latency: got %b expected 0", obs_sync[0]); else passes++;
        checks++; if (obs_valid[5] !== 1'b0) $display("FAIL p8_valid_early: got %b expected 0", obs_valid[5]); else passes++;
        checks++; if (obs_bit[5] !== 1'b1) $display("FAIL p8_bit_before: got %b expected 1", obs_bit[5]); else passes++;
        checks++; if (obs_valid[6] !== 1'b1) $display("FAIL p8_valid: got %b expected 1", obs_valid[6]); else passes++;
        checks++; if (obs_edge[6] !== 6'd6) $display("FAIL p8_valid_edge: got %0d expected 6", obs_edge[6]); else passes++;
        checks++; if (obs_bit[6] !== 1'b0) $display("FAIL p8_sampled_bit: got %b expected 0", obs_bit[6]); else passes++;
        checks++; if (obs_valid[7] !== 1'b0) $display("FAIL p8_valid_one_cycle: got %b expected 0", obs_valid[7]); else passes++;
        checks++; if (obs_bit[7] !== 1'b0) $display("FAIL p8_bit_hold: got %b expected 0", obs_bit[7]); else passes++;
    endtask

    task automatic test_majority_p16();
        int pulses;
        clear_plan();
        prescale = PRESCALE_16;
        plan[8]  = 1'b0;  // bit 0: samples 1,0,1
        plan[23] = 1'b0;  // bit 1: samples 0,0,1
        plan[24] = 1'b0;
        for (int i = 0; i < 32; i++) en_plan[i] = 1'b1;
        run_frame(32);
        pulses = 0;
        for (int i = 0; i < 32; i++) if (obs_valid[i] === 1'b1) pulses++;
        checks++; if (obs_sync[7] !== 1'b1 || obs_sync[8] !== 1'b0) $display("FAIL p16_glitch_align: got %b%b expected 10", obs_sync[7], obs_sync[8]); else passes++;
        checks++; if (obs_bit[9] !== 1'b0) $display("FAIL p16_bit_before: got %b expected 0", obs_bit[9]); else passes++;
        checks++; if (obs_valid[10] !== 1'b1) $display("FAIL p16_valid0: got %b expected 1", obs_valid[10]); else passes++;
        checks++; if (obs_bit[10] !== 1'b1) $display("FAIL p16_single_glitch: got %b expected 1", obs_bit[10]); else passes++;
        checks++; if (obs_bit[25] !== 1'b1) $display("FAIL p16_hold: got %b expected 1", obs_bit[25]); else passes++;
        checks++; if (obs_valid[26] !== 1'b1) $display("FAIL p16_valid1: got %b expected 1", obs_valid[26]); else passes++;
        checks++; if (obs_bit[26] !== 1'b0) $display("FAIL p16_double_glitch: got %b expected 0", obs_bit[26]); else passes++;
        checks++; if (pulses != 2) $display("FAIL p16_pulse_count: got %0d expected 2", pulses); else passes++;
    endtask

    task automatic test_samp_en_drop();
        int pulses0, pulses1;
        clear_plan();
        prescale = PRESCALE_8;
        for (int i = 0; i < 16; i++) en_plan[i] = 1'b1;
        en_plan[4] = 1'b0;
        run_frame(16);
        pulses0 = 0;
        pulses1 = 0;
        for (int i = 0; i < 8; i++) if (obs_valid[i] === 1'b1) pulses0++;
        for (int i = 8; i < 16; i++) if (obs_valid[i] === 1'b1) pulses1++;
        checks++; if (pulses0 != 0) $display("FAIL drop_no_valid: got %0d expected 0", pulses0); else passes++;
        checks++; if (obs_bit[7] !== 1'b0) $display("FAIL drop_bit_held: got %b expected 0", obs_bit[7]); else passes++;
        checks++; if (obs_valid[14] !== 1'b1) $display("FAIL drop_next_valid: got %b expected 1", obs_valid[14]); else passes++;
        checks++; if (obs_bit[14] !== 1'b1) $display("FAIL drop_next_bit: got %b expected 1", obs_bit[14]); else passes++;
        checks++; if (pulses1 != 1) $display("FAIL drop_next_count: got %0d expected 1", pulses1); else passes++;
    endtask

    task automatic test_saturation();
        clear_plan();
        prescale = PRESCALE_8;
        run_frame(137);
        checks++; if (obs_bcnt[119] !== 4'd14) $display("FAIL sat_pre: got %0d expected 14", obs_bcnt[119]); else passes++;
        checks++; if (obs_bcnt[120] !== 4'd15) $display("FAIL sat_reach: got %0d expected 15", obs_bcnt[120]); else passes++;
        checks++; if (obs_bcnt[136] !== 4'd15) $display("FAIL sat_hold: got %0d expected 15", obs_bcnt[136]); else passes++;
        checks++; if (obs_edge[136] !== 6'd0) $display("FAIL sat_edge: got %0d expected 0", obs_edge[136]); else passes++;
    endtask

    task automatic test_reset_mid_frame();
        clear_plan();
        prescale = PRESCALE_8;
        for (int i = 0; i < 40; i++) begin
            plan[i]    = 1'b0;
            en_plan[i] = 1'b1;
        end
        run_frame(29);
        checks++; if (edge_cnt !== 6'd5 || bit_cnt !== 4'd3) $display("FAIL mid_position: got edge=%0d bit=%0d expected 5/3", edge_cnt, bit_cnt); else passes++;
        checks++; if (sampled_bit !== 1'b0) $display("FAIL mid_sampled_before: got %b expected 0", sampled_bit); else passes++;
        reset_n = 1'b0;
        #1;
        checks++; if (edge_cnt !== 6'd0 || bit_cnt !== 4'd0) $display("FAIL mid_reset_counters: got edge=%0d bit=%0d expected 0/0", edge_cnt, bit_cnt); else passes++;
        checks++; if (sampled_bit !== 1'b1) $display("FAIL mid_reset_sampled_bit: got %b expected 1", sampled_bit); else passes++;
        checks++; if (sample_valid !== 1'b0 || bit_done !== 1'b0) $display("FAIL mid_reset_strobes: got valid=%b done=%b expected 0/0", sample_valid, bit_done); else passes++;
        checks++; if (rx_sync !== 1'b1) $display("FAIL mid_reset_rx_sync: got %b expected 1", rx_sync); else passes++;
        @(negedge clk);
        cnt_en  = 1'b1;
        reset_n = 1'b1;
        #1;
        checks++; if (edge_cnt !== 6'd0 || bit_cnt !== 4'd0) $display("FAIL restart_start: got edge=%0d bit=%0d expected 0/0", edge_cnt, bit_cnt); else passes++;
        for (int k = 1; k < 10; k++) begin
            @(negedge clk);
            checks++; if (edge_cnt !== 6'(k % 8) || bit_cnt !== 4'(k / 8)) $display("FAIL restart_count[%0d]: got edge=%0d bit=%0d expected %0d/%0d", k, edge_cnt, bit_cnt, k % 8, k / 8); else passes++;
        end
        cnt_en = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_counting();
        test_majority_p8();
        test_majority_p16();
        test_samp_en_drop();
        test_saturation();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
